// File: rtl/game_pkg.sv
// Shared constants and types for the who_win match-result decoder.
// Holds the LCD result codes, the score width and the default win threshold.
package game_pkg;

    localparam int unsigned SCORE_W       = 9;
    localparam int unsigned RES_W         = 2;
    localparam int unsigned WIN_SCORE_DEF = 100;

    typedef logic [SCORE_W-1:0] score_t;
    typedef logic [RES_W-1:0]   res_t;

    localparam res_t RES_PLAYING = 2'b00;
    localparam res_t RES_A_WIN   = 2'b01;
    localparam res_t RES_B_WIN   = 2'b10;
    localparam res_t RES_DRAW    = 2'b11;

    // State encoding matches the result codes so the register drives the LCD as-is.
    typedef enum logic [RES_W-1:0] {
        PLAYING = RES_PLAYING,
        A_WIN   = RES_A_WIN,
        B_WIN   = RES_B_WIN,
        DRAW    = RES_DRAW
    } state_t;

endpackage

// File: rtl/who_win_if.sv
// Score / result bus between the score counters, who_win and the LCD driver.
//   scoreA, scoreB : player scores (unsigned, SCORE_W bits)
//   LCD_sig        : registered result code towards the LCD controller
// master: score source / result consumer; slave: the who_win decoder.
interface who_win_if;
    import game_pkg::*;

    score_t scoreA;
    score_t scoreB;
    res_t   LCD_sig;

    modport master (
        output scoreA,
        output scoreB,
        input  LCD_sig
    );

    modport slave (
        input  scoreA,
        input  scoreB,
        output LCD_sig
    );
endinterface

// File: rtl/score_judge.sv
// Combinational judge: maps the two current scores to the result code the game
// would settle on this cycle (RES_PLAYING when nobody has qualified yet).
//   scoreA, scoreB : player scores
//   next_res_c     : candidate result code (combinational)
module score_judge
    import game_pkg::*;
#(
    parameter int unsigned WIN_SCORE = WIN_SCORE_DEF
) (
    input  score_t scoreA,
    input  score_t scoreB,
    output res_t   next_res_c
);

    localparam score_t WIN_TH = SCORE_W'(WIN_SCORE);

    logic qa;
    logic qb;

    assign qa = (scoreA >= WIN_TH);
    assign qb = (scoreB >= WIN_TH);

    // Only a qualified player can win; size of the lead is irrelevant otherwise.
    always_comb begin
        next_res_c = RES_PLAYING;
        if (qa && !qb) begin
            next_res_c = RES_A_WIN;
        end else if (qb && !qa) begin
            next_res_c = RES_B_WIN;
        end else if (qa && qb) begin
            if (scoreA > scoreB) begin
                next_res_c = RES_A_WIN;
            end else if (scoreB > scoreA) begin
                next_res_c = RES_B_WIN;
            end else begin
                next_res_c = RES_DRAW;
            end
        end
    end

endmodule

// File: rtl/who_win.sv
// Match-result decoder: latches the first decided result of the game and
// shows it on LCD_sig until reset.
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset, returns to PLAYING
//   bus  : slave side of who_win_if (scoreA, scoreB in; LCD_sig out, registered)
module who_win
    import game_pkg::*;
#(
    parameter int unsigned WIN_SCORE = WIN_SCORE_DEF
) (
    input  logic       clk,
    input  logic       rst,
    who_win_if.slave   bus
);

    state_t state_q;
    state_t state_d;
    res_t   judge_res_c;

    score_judge #(
        .WIN_SCORE (WIN_SCORE)
    ) u_judge (
        .scoreA     (bus.scoreA),
        .scoreB     (bus.scoreB),
        .next_res_c (judge_res_c)
    );

    // State register; reset wins over everything, so scores are don't-care in reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= PLAYING;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: only PLAYING listens to the judge, results are terminal.
    always_comb begin
        state_d = state_q;
        case (state_q)
            PLAYING: state_d = state_t'(judge_res_c);
            A_WIN:   state_d = A_WIN;
            B_WIN:   state_d = B_WIN;
            DRAW:    state_d = DRAW;
            default: state_d = PLAYING;
        endcase
    end

    assign bus.LCD_sig = res_t'(state_q);

endmodule

// File: tb/tb_who_win.sv
// Directed testbench for who_win: a vector table applied one clock per entry,
// plus hand-written sequences for latency and result latching.
module tb_who_win;
    import game_pkg::*;

    typedef struct packed {
        logic       rst;
        logic [8:0] a;
        logic [8:0] b;
        logic [1:0] exp;
    } vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    vec_t vecs[$];

    who_win_if bus ();

    who_win #(
        .WIN_SCORE (100)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(logic r, logic [8:0] a, logic [8:0] b, logic [1:0] e);
        vec_t v;
        v.rst = r;
        v.a   = a;
        v.b   = b;
        v.exp = e;
        return v;
    endfunction

    task automatic check(input string name, input logic [1:0] exp);
        checks++;
        if (bus.LCD_sig !== exp) begin
            errors++;
            $display("FAIL %s: LCD_sig=%b expected %b", name, bus.LCD_sig, exp);
        end
    endtask

    // Drive inputs, take one rising edge, sample 1 time unit later.
    task automatic step(input logic r, input logic [8:0] a, input logic [8:0] b);
        rst        = r;
        bus.scoreA = a;
        bus.scoreB = b;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rst        = 1'b1;
        bus.scoreA = 'x;
        bus.scoreB = 'x;

        // {rst, scoreA, scoreB, expected LCD_sig after the edge}
        vecs.push_back(mk(1'b1, 9'bx,  9'bx,  2'b00)); // X scores in reset
        vecs.push_back(mk(1'b1, 9'd300, 9'd200, 2'b00)); // winning scores held off by reset
        vecs.push_back(mk(1'b0, 9'd1,   9'd13,  2'b00));
        vecs.push_back(mk(1'b0, 9'd193, 9'd13,  2'b01));
        vecs.push_back(mk(1'b0, 9'd1,   9'd205, 2'b01)); // latched
        vecs.push_back(mk(1'b1, 9'd1,   9'd205, 2'b00));
        vecs.push_back(mk(1'b0, 9'd1,   9'd205, 2'b10));
        vecs.push_back(mk(1'b1, 9'd150, 9'd150, 2'b00));
        vecs.push_back(mk(1'b0, 9'd150, 9'd150, 2'b11));
        vecs.push_back(mk(1'b1, 9'd150, 9'd150, 2'b00)); // one-cycle pulse clears draw
        vecs.push_back(mk(1'b0, 9'd99,  9'd0,   2'b00)); // just below threshold
        vecs.push_back(mk(1'b0, 9'd100, 9'd99,  2'b01)); // exactly at threshold
        vecs.push_back(mk(1'b1, 9'd0,   9'd0,   2'b00));
        vecs.push_back(mk(1'b0, 9'd120, 9'd511, 2'b10)); // max score, both qualified
        vecs.push_back(mk(1'b1, 9'd120, 9'd511, 2'b00)); // reset mid B_WIN
        vecs.push_back(mk(1'b1, 9'd120, 9'd511, 2'b00));
        vecs.push_back(mk(1'b0, 9'd120, 9'd511, 2'b10));
        vecs.push_back(mk(1'b1, 9'd0,   9'd0,   2'b00));
        vecs.push_back(mk(1'b0, 9'd100, 9'd100, 2'b11)); // tie at threshold
        vecs.push_back(mk(1'b1, 9'd0,   9'd0,   2'b00));
        vecs.push_back(mk(1'b0, 9'd99,  9'd99,  2'b00)); // tie below threshold
        vecs.push_back(mk(1'b0, 9'd99,  9'd500, 2'b10)); // only B qualifies
        vecs.push_back(mk(1'b1, 9'd0,   9'd0,   2'b00));
        vecs.push_back(mk(1'b0, 9'd511, 9'd511, 2'b11));
        vecs.push_back(mk(1'b1, 9'd0,   9'd0,   2'b00));
        vecs.push_back(mk(1'b0, 9'd200, 9'd150, 2'b01)); // both qualified, A ahead
        vecs.push_back(mk(1'b1, 9'd0,   9'd0,   2'b00));
        vecs.push_back(mk(1'b0, 9'd150, 9'd200, 2'b10)); // both qualified, B ahead
        vecs.push_back(mk(1'b1, 9'd0,   9'd0,   2'b00));
        vecs.push_back(mk(1'b0, 9'd511, 9'd100, 2'b01));
        vecs.push_back(mk(1'b1, 9'd0,   9'd0,   2'b00));
        vecs.push_back(mk(1'b0, 9'd0,   9'd99,  2'b00)); // large lead, nobody qualified

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].a, vecs[i].b);
            check($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Latency: no combinational path from scores to LCD_sig.
        step(1'b1, 9'd0, 9'd0);
        check("lat_reset", 2'b00);
        rst        = 1'b0;
        bus.scoreA = 9'd193;
        bus.scoreB = 9'd13;
        #2;
        check("lat_before_edge", 2'b00);
        @(posedge clk);
        #1;
        check("lat_after_edge", 2'b01);

        // Terminal state ignores every later score pattern.
        for (int k = 0; k < 6; k++) begin
            step(1'b0, 9'(k * 97), 9'(511 - k * 53));
            check($sformatf("hold_a%0d", k), 2'b01);
        end

        // Reset held several cycles with winning scores keeps 00 throughout.
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 9'd0, 9'd400);
            check($sformatf("rst_hold%0d", k), 2'b00);
        end
        step(1'b0, 9'd0, 9'd400);
        check("release_b", 2'b10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/who_win.md
Name: who_win

Overview:
- Match-result decoder for a two-player score game.
- Samples the two 9-bit player scores every clock and decides whether player A or player B has won, or whether the game is a draw.
- Drives a 2-bit status code to the LCD controller, which shows the result text.
- Sits between the score counters and the LCD driver. The result latches until reset.

Parameters:
- WIN_SCORE, 100, minimum unsigned score (0..511) that qualifies a player to win.
- SCORE_W, 9, width of each score input; fixed at 9 for this project.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- scoreA  input  9  player A score, unsigned binary.
- scoreB  input  9  player B score, unsigned binary.
- LCD_sig  output  2  result code, registered: 2'b00 playing / no result, 2'b01 A wins, 2'b10 B wins, 2'b11 draw.

Behaviour:
- FSM states: PLAYING, A_WIN, B_WIN, DRAW.
  - Encoding: PLAYING=2'b00, A_WIN=2'b01, B_WIN=2'b10, DRAW=2'b11.
  - LCD_sig equals the state register directly; no combinational path from the inputs to LCD_sig.
- Reset: on a rising clk edge with rst=1, state goes to PLAYING and LCD_sig=2'b00.
  - Reset overrides all other conditions and is honoured in any state, including mid-result.
  - While rst stays high, LCD_sig holds 2'b00 regardless of the scores.
- Qualification flags, computed each cycle: qa = (scoreA >= WIN_SCORE), qb = (scoreB >= WIN_SCORE). All comparisons are unsigned 9-bit.
- Transitions from PLAYING:
  - qa and not qb -> A_WIN.
  - qb and not qa -> B_WIN.
  - qa and qb and scoreA > scoreB -> A_WIN.
  - qa and qb and scoreB > scoreA -> B_WIN.
  - qa and qb and scoreA == scoreB -> DRAW.
  - Neither qualified -> stay in PLAYING. This holds even if one score is much larger than the other.
- A_WIN, B_WIN and DRAW are terminal. They hold until rst, and later score changes are ignored.
- Latency: a qualifying input sampled at edge N appears on LCD_sig after edge N (one cycle).
- Boundaries:
  - Score exactly equal to WIN_SCORE qualifies.
  - WIN_SCORE-1 does not qualify.
  - 511 is a valid score; there is no wrap or saturation logic.
- X/undriven scores while in reset must not affect the outputs.

Decomposition:
- Shared package game_pkg holds:
  - the result-code constants RES_PLAYING, RES_A_WIN, RES_B_WIN, RES_DRAW;
  - the score width constant SCORE_W=9;
  - the default WIN_SCORE.
- One natural sub-module: score_judge. It is purely combinational: it takes scoreA, scoreB and WIN_SCORE and returns the next-result code. who_win wraps it with the state register and the latching FSM.

Test Plan:
- Reset with rst=1 and any scores -> LCD_sig=00 on every cycle while rst=1. Release rst with scoreA=1, scoreB=13 -> LCD_sig stays 00.
- From reset release, scoreA=193 (9'b011000001), scoreB=13 -> LCD_sig=01 one cycle later. Then change to scoreA=1, scoreB=205 -> LCD_sig stays 01 (latched).
- Reset pulse, then scoreA=1, scoreB=205 (9'b011001101) -> LCD_sig=10 one cycle after sampling.
- Reset, then scoreA=150, scoreB=150 -> LCD_sig=11. Then pulse rst for one cycle -> LCD_sig=00 on the edge after rst is sampled high.
- Threshold edges:
  - scoreA=99, scoreB=0 -> 00.
  - scoreA=100, scoreB=99 -> 01.
  - After reset, scoreA=120, scoreB=511 -> 10.
- Reset asserted mid-game while in B_WIN and the scores remain winning -> 00 during reset. On release, 10 again one cycle after the first non-reset edge.
